bitscan_encdec: RTL and testbench

- Parametrised, registered successor to the combinational 4-in/8-out one-hot address encoder used by the 2D FIR datapath.
- Accepts an IN_W-bit request vector through a valid/ready handshake and emits one-hot coefficient/tap addresses plus a binary index.
- Two modes, selected per request:
  - Single: one address, for the priority set bit.
  - Scan: one address per set bit, one per cycle, ending with a last marker.
- Sits between the FIR control sequencer and the coefficient/line-buffer address mux.

---
 rtl/bitscan_encdec.sv | 138 +++++++++++++
 tb/tb_bitscan_encdec.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bitscan_encdec.sv
// Registered bit-scan encoder: request vector in, one-hot address + binary index out.
// Latency: first output visible the cycle after accept; scan emits one set bit per output handshake.
// Backpressure: outputs hold while out_valid && !out_ready; in_ready is low for the whole scan.
module bitscan_encdec #(
    parameter int IN_W     = 8,
    parameter int IDX_W    = $clog2(IN_W),
    parameter bit PRIO_LSB = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IN_W-1:0]  address,
    output logic [IDX_W-1:0] index,
    output logic [IDX_W:0]   count,
    output logic             last,
    output logic             empty
);

    typedef enum logic {IDLE, SCAN} state_t;

    typedef struct packed {
        logic [IN_W-1:0]  address;
        logic [IDX_W-1:0] index;
        logic [IDX_W:0]   count;
        logic             last;
        logic             empty;
    } out_t;

    localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

    // Later matches overwrite earlier ones, so the loop direction selects the priority end.
    function automatic logic [IDX_W-1:0] pick(input logic [IN_W-1:0] v);
        logic [IDX_W-1:0] p;
        p = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (PRIO_LSB) begin
                if (v[IN_W-1-i]) p = IDX_W'(IN_W-1-i);
            end else begin
                if (v[i]) p = IDX_W'(i);
            end
        end
        return p;
    endfunction

    function automatic logic [IN_W-1:0] onehot(input logic [IDX_W-1:0] p);
        logic [IN_W-1:0] oh;
        oh    = '0;
        oh[p] = 1'b1;
        return oh;
    endfunction

    state_t          state_q, state_d;
    logic [IN_W-1:0] rem_q, rem_d;
    logic            out_valid_q, out_valid_d;
    out_t            out_q, out_d;

    logic             accept;
    logic             out_fire;
    logic [IN_W-1:0]  src_vec;
    logic [IDX_W-1:0] pick_idx;
    logic [IN_W-1:0]  pick_oh;
    logic [IN_W-1:0]  rem_next;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // One pick/decode shared between a fresh request and the scan remainder.
    assign src_vec  = (state_q == SCAN) ? rem_q : in_data;
    assign pick_idx = pick(src_vec);
    assign pick_oh  = onehot(pick_idx);
    assign rem_next = src_vec & ~pick_oh;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            out_valid_d = 1'b1;
            if (in_data == '0) begin
                out_d   = '{address: '0, index: '0, count: '0, last: 1'b1, empty: 1'b1};
                rem_d   = '0;
                state_d = IDLE;
            end else begin
                out_d.address = pick_oh;
                out_d.index   = pick_idx;
                out_d.count   = CNT_ONE;
                out_d.empty   = 1'b0;
                if (in_mode) begin
                    out_d.last = (rem_next == '0);
                    rem_d      = rem_next;
                    state_d    = (rem_next != '0) ? SCAN : IDLE;
                end else begin
                    out_d.last = 1'b1;
                    rem_d      = '0;
                    state_d    = IDLE;
                end
            end
        end else if ((state_q == SCAN) && out_fire) begin
            out_d.address = pick_oh;
            out_d.index   = pick_idx;
            out_d.count   = out_q.count + CNT_ONE;
            out_d.last    = (rem_next == '0);
            rem_d         = rem_next;
            state_d       = (rem_next != '0) ? SCAN : IDLE;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign address   = out_q.address;
    assign index     = out_q.index;
    assign count     = out_q.count;
    assign last      = out_q.last;
    assign empty     = out_q.empty;

endmodule

// File: tb/tb_bitscan_encdec.sv
// Directed bench for bitscan_encdec: table of requests plus reset, backpressure and back-to-back sequences.
module tb_bitscan_encdec;

    localparam int IN_W  = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid, in_ready, in_mode, out_valid, out_ready, last, empty;
    logic [IN_W-1:0]  in_data, address;
    logic [IDX_W-1:0] index;
    logic [IDX_W:0]   count;

    logic             in_valid_m, in_ready_m, in_mode_m, out_valid_m, out_ready_m, last_m, empty_m;
    logic [IN_W-1:0]  in_data_m, address_m;
    logic [IDX_W-1:0] index_m;
    logic [IDX_W:0]   count_m;

    int checks = 0;
    int errors = 0;

    bitscan_encdec #(.IN_W(IN_W), .IDX_W(IDX_W), .PRIO_LSB(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .address(address),
        .index(index), .count(count), .last(last), .empty(empty)
    );

    bitscan_encdec #(.IN_W(IN_W), .IDX_W(IDX_W), .PRIO_LSB(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid_m), .in_ready(in_ready_m), .in_data(in_data_m),
        .in_mode(in_mode_m), .out_valid(out_valid_m), .out_ready(out_ready_m), .address(address_m),
        .index(index_m), .count(count_m), .last(last_m), .empty(empty_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        mode;
        int          n;
        logic        is_empty;
        logic [63:0] addrs;  // byte k = expected address of output k
        logic [31:0] idxs;   // nibble k = expected index of output k
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int guard;
        guard     = 0;
        out_ready = 1'b1;
        #1;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        chk($sformatf("v%0d_ready_before", vi), 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = v.data;
        in_mode  = v.mode;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        in_mode  = 1'b0;
        #1;
        for (int k = 0; k < v.n; k++) begin
            chk($sformatf("v%0d_valid%0d", vi, k), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_addr%0d", vi, k), 64'(address), 64'(v.addrs[8*k +: 8]));
            chk($sformatf("v%0d_idx%0d", vi, k), 64'(index), 64'(v.idxs[4*k +: 3]));
            chk($sformatf("v%0d_count%0d", vi, k), 64'(count), v.is_empty ? 64'd0 : 64'(k+1));
            chk($sformatf("v%0d_last%0d", vi, k), 64'(last), (k == v.n-1) ? 64'd1 : 64'd0);
            chk($sformatf("v%0d_empty%0d", vi, k), 64'(empty), 64'(v.is_empty));
            chk($sformatf("v%0d_inready%0d", vi, k), 64'(in_ready), (k == v.n-1) ? 64'd1 : 64'd0);
            step();
        end
        chk($sformatf("v%0d_drained", vi), 64'(out_valid), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int          k;
        int          cyc;
        logic        r;
        logic        prev_stall;
        logic [7:0]  prev_addr;
        logic [31:0] bp_exp;

        vecs[0] = '{data: 8'b0110_1000, mode: 1'b0, n: 1, is_empty: 1'b0, addrs: 64'h08, idxs: 32'h3};
        vecs[1] = '{data: 8'hA5, mode: 1'b1, n: 4, is_empty: 1'b0, addrs: 64'h80_20_04_01, idxs: 32'h7520};
        vecs[2] = '{data: 8'h00, mode: 1'b1, n: 1, is_empty: 1'b1, addrs: 64'h00, idxs: 32'h0};
        vecs[3] = '{data: 8'hFF, mode: 1'b1, n: 8, is_empty: 1'b0,
                    addrs: 64'h80_40_20_10_08_04_02_01, idxs: 32'h76543210};
        vecs[4] = '{data: 8'h80, mode: 1'b1, n: 1, is_empty: 1'b0, addrs: 64'h80, idxs: 32'h7};
        vecs[5] = '{data: 8'h00, mode: 1'b0, n: 1, is_empty: 1'b1, addrs: 64'h00, idxs: 32'h0};
        vecs[6] = '{data: 8'h18, mode: 1'b0, n: 1, is_empty: 1'b0, addrs: 64'h08, idxs: 32'h3};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
        in_valid_m = 1'b0; in_data_m = '0; in_mode_m = 1'b0; out_ready_m = 1'b1;

        // Reset and initial state
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_last", 64'(last), 64'd0);
        chk("rst_empty", 64'(empty), 64'd0);
        chk("rst_msb_out_valid", 64'(out_valid_m), 64'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // MSB-priority single mode
        in_valid_m = 1'b1; in_data_m = 8'b0110_1000; in_mode_m = 1'b0;
        step();
        in_valid_m = 1'b0; in_data_m = '0;
        chk("msb_valid", 64'(out_valid_m), 64'd1);
        chk("msb_addr", 64'(address_m), 64'h40);
        chk("msb_idx", 64'(index_m), 64'd6);
        chk("msb_count", 64'(count_m), 64'd1);
        chk("msb_last", 64'(last_m), 64'd1);
        step();
        chk("msb_drained", 64'(out_valid_m), 64'd0);

        // Backpressure on an 8'h0F scan
        bp_exp = 32'h08_04_02_01;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h0F; in_mode = 1'b1;
        step();
        in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        k = 0; cyc = 0; prev_stall = 1'b0; prev_addr = '0;
        while (k < 4 && cyc < 200) begin
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            if (prev_stall) chk("bp_hold", 64'(address), 64'(prev_addr));
            if (r) begin
                chk($sformatf("bp_addr%0d", k), 64'(address), 64'(bp_exp[8*k +: 8]));
                chk($sformatf("bp_count%0d", k), 64'(count), 64'(k+1));
                k++;
            end
            prev_stall = !r;
            prev_addr  = address;
            step();
            cyc++;
        end
        chk("bp_items", 64'(k), 64'd4);
        out_ready = 1'b1;
        #1;
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Back-to-back: 8'h03 loads while the only item of 8'h10 is consumed
        in_valid = 1'b1; in_data = 8'h10; in_mode = 1'b1;
        step();
        chk("b2b_first_addr", 64'(address), 64'h10);
        chk("b2b_first_last", 64'(last), 64'd1);
        in_data = 8'h03;
        #1;
        chk("b2b_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_addr0", 64'(address), 64'h01);
        chk("b2b_count0", 64'(count), 64'd1);
        chk("b2b_last0", 64'(last), 64'd0);
        step();
        chk("b2b_addr1", 64'(address), 64'h02);
        chk("b2b_last1", 64'(last), 64'd1);
        step();
        chk("b2b_drained", 64'(out_valid), 64'd0);

        // Reset in the middle of an 8'hFF scan
        in_valid = 1'b1; in_data = 8'hFF; in_mode = 1'b1;
        step();
        in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        step();
        step();
        chk("midrst_pre_addr", 64'(address), 64'h04);
        rst = 1'b1;
        step();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_address", 64'(address), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("midrst_no_stale%0d", i), 64'(out_valid), 64'd0);
        end
        chk("midrst_in_ready", 64'(in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
